// File: rtl/led_pattern_ctrl.sv
// Bus-programmable sequencer for the 8-LED bank: static, blink, scroll and PWM patterns.
// A prescaler paces blink and scroll; writes to DATA or CTRL restart the running pattern.
module led_pattern_ctrl #(
  parameter int                  PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd999999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_PWM    = 2'b11
  } mode_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_DUTY   = 2'd3;

  logic [7:0]          r_pattern;
  logic                r_enable;
  mode_t               r_mode;
  logic [PERIOD_W-1:0] r_period;
  logic [7:0]          r_duty;
  logic [PERIOD_W-1:0] r_presc_cnt;
  logic                r_phase;
  logic [7:0]          r_shreg;
  logic [7:0]          r_pwm_cnt;

  logic                w_wr_data;
  logic                w_wr_ctrl;
  logic                w_wr_period;
  logic                w_wr_duty;
  logic                w_restart;
  logic                w_tick;
  logic [7:0]          w_new_pattern;
  logic [7:0]          w_led_next;
  logic [31:0]         w_rd_mux;
  logic                w_unused;

  assign w_wr_data     = wr_en && (addr[3:2] == REG_DATA);
  assign w_wr_ctrl     = wr_en && (addr[3:2] == REG_CTRL);
  assign w_wr_period   = wr_en && (addr[3:2] == REG_PERIOD);
  assign w_wr_duty     = wr_en && (addr[3:2] == REG_DUTY);
  assign w_restart     = w_wr_data || w_wr_ctrl;
  assign w_tick        = (r_presc_cnt == r_period);
  assign w_new_pattern = w_wr_data ? wdata[7:0] : r_pattern;
  assign w_unused      = ^{addr[1:0], wdata[31:8]};

  // LED value is a pure function of the current state; the register adds one edge of latency.
  always_comb begin
    w_led_next = 8'h00;
    if (r_enable) begin
      case (r_mode)
        MODE_STATIC: w_led_next = r_pattern;
        MODE_BLINK:  w_led_next = r_phase ? r_pattern : 8'h00;
        MODE_SCROLL: w_led_next = r_shreg;
        MODE_PWM:    w_led_next = (r_pwm_cnt < r_duty) ? r_pattern : 8'h00;
        default:     w_led_next = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (addr[3:2])
      REG_DATA:   w_rd_mux = {24'd0, r_pattern};
      REG_CTRL:   w_rd_mux = {29'd0, r_mode, r_enable};
      REG_PERIOD: w_rd_mux = 32'(r_period);
      REG_DUTY:   w_rd_mux = {24'd0, r_duty};
      default:    w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led         <= 8'h00;
      rdata       <= 32'd0;
      r_pattern   <= 8'h00;
      r_enable    <= 1'b0;
      r_mode      <= MODE_STATIC;
      r_period    <= DEFAULT_PERIOD;
      r_duty      <= 8'h00;
      r_presc_cnt <= '0;
      r_phase     <= 1'b1;
      r_shreg     <= 8'h00;
      r_pwm_cnt   <= 8'h00;
    end else begin
      led <= w_led_next;
      if (rd_en)
        rdata <= w_rd_mux;

      if (w_wr_data)
        r_pattern <= wdata[7:0];
      if (w_wr_ctrl) begin
        r_enable <= wdata[0];
        r_mode   <= mode_t'(wdata[2:1]);
      end
      if (w_wr_period)
        r_period <= wdata[PERIOD_W-1:0];
      if (w_wr_duty)
        r_duty <= wdata[7:0];

      // A restarting write or a PERIOD write in a tick cycle swallows that tick.
      if (!r_enable || w_restart) begin
        r_presc_cnt <= '0;
        r_pwm_cnt   <= 8'h00;
        r_phase     <= 1'b1;
        r_shreg     <= w_new_pattern;
      end else begin
        if (w_wr_period || w_tick)
          r_presc_cnt <= '0;
        else
          r_presc_cnt <= r_presc_cnt + 1'b1;

        if (r_mode == MODE_PWM)
          r_pwm_cnt <= r_pwm_cnt + 8'd1;

        if (w_tick && !w_wr_period) begin
          if (r_mode == MODE_BLINK)
            r_phase <= ~r_phase;
          if (r_mode == MODE_SCROLL)
            r_shreg <= {r_shreg[6:0], r_shreg[7]};
        end
      end
    end
  end

endmodule
